bounce_generator: RTL
=====================

# bounce_generator

Synthesizable switch-bounce emulator: converts a clean level `clean_in` into a `bouncy_out` that chatters for a fixed window after every change, then settles to the new level. It is the driving end of the debouncer path. Used on-FPGA and in benches as the stimulus source for debouncer instances, replacing a mechanical button. Chatter is a pseudo-random LFSR sequence or a deterministic alternating pattern, selected at compile time.

## Interface
- `BOUNCE_TICKS`, 10: length of the chatter window in enabled ticks; must be ≥1.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be nonzero. Used only with `BOUNCE_GEN_LFSR_EN`.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `tick`  in  1  step enable; state advances only on edges where `tick`=1.
- `clean_in`  in  1  ideal commanded level.
- `bouncy_out`  out  1  emulated switch output, registered.
- `busy`  out  1  high while in a bounce state (combinational from state).

## Operation
- States: S_STABLE_0, S_BOUNCE_TO_1, S_STABLE_1, S_BOUNCE_TO_0. Target level is 1 for S_BOUNCE_TO_1 and 0 for S_BOUNCE_TO_0.
- Counter width is $clog2(BOUNCE_TICKS)+1 bits. `n` is the counter value.
- Sample for target `t` at index `n`:
  - With the macro: `lfsr[0]`.
  - Without the macro: `t ^ n[0]`.
- All updates below occur only on edges with `rst`=0 and `tick`=1. When `tick`=0, state, counter, `bouncy_out` and LFSR all hold.
- S_STABLE_0:
  - `bouncy_out`<=0.
  - If `clean_in`=1: counter<=1, state<=S_BOUNCE_TO_1, `bouncy_out`<=sample(t=1, n=0).
- S_STABLE_1: mirror of S_STABLE_0, triggered by `clean_in`=0.
- S_BOUNCE_TO_1:
  - If `clean_in`=0 (reversal): state<=S_BOUNCE_TO_0, counter<=1, `bouncy_out`<=sample(t=0, n=0).
  - Else if counter==BOUNCE_TICKS: state<=S_STABLE_1, `bouncy_out`<=1.
  - Else: `bouncy_out`<=sample(t=1, n=counter), counter<=counter+1.
- S_BOUNCE_TO_0: mirror of S_BOUNCE_TO_1.
- Reversal takes priority over window completion.
- Illegal or default state: go to S_STABLE_0, `bouncy_out`<=0.
- LFSR:
  - 16-bit Galois, right shift, feedback mask 16'hB400.
  - Next value = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 0).
  - Advances on every `tick` edge regardless of state.

## Timing
- Reset values: state S_STABLE_0, counter 0, `bouncy_out`=0, `busy`=0, LFSR=`LFSR_SEED`.
- Reset mid-bounce aborts the window immediately; there is no residual chatter.
- For a change of `clean_in` sampled at tick edge k:
  - Chatter samples appear after tick edges k … k+BOUNCE_TICKS−1 (exactly BOUNCE_TICKS samples).
  - `bouncy_out` equals the new level from tick edge k+BOUNCE_TICKS onward.
- `busy` is high from edge k until edge k+BOUNCE_TICKS.
- A `clean_in` pulse shorter than one tick can be missed; this is intended.
- BOUNCE_TICKS=1 gives a single chatter sample, then stable.

## Configuration
- `BOUNCE_GEN_LFSR_EN`:
  - Defined: LFSR is instantiated and chatter samples are `lfsr[0]`.
  - Undefined: no LFSR registers; chatter is the deterministic pattern `t ^ n[0]` (target, ~target, target, …), and `LFSR_SEED` is ignored.

## Test plan
- No macro, BOUNCE_TICKS=4, `tick`=1:
  - `clean_in` 0→1 at edge k -> `bouncy_out`=1,0,1,0 after edges k..k+3, then 1 from k+4.
  - `busy` is high for exactly 4 cycles.
- No macro, BOUNCE_TICKS=4, in S_STABLE_1:
  - `clean_in` 1→0 -> `bouncy_out`=0,1,0,1, then 0.
  - `clean_in` restored to 1 after 2 samples -> restart toward 1, giving 1,0,1,0, then 1 with no S_STABLE_0 visit.
- `tick` asserted every 3rd cycle, BOUNCE_TICKS=4 -> each sample is held 3 cycles; stable after 12 cycles; LFSR is frozen on non-tick cycles.
- `rst` pulsed during the 2nd bounce sample -> next cycle `bouncy_out`=0, `busy`=0, state S_STABLE_0; held `clean_in`=1 then restarts a full 4-sample window.
- `BOUNCE_GEN_LFSR_EN` defined, seed 16'hACE1, BOUNCE_TICKS=4, `clean_in`=1 on the first edge after reset -> `bouncy_out`=1,0,0,0, then 1; LFSR states ACE1→E270→7138→389C→1C4E.
- Back-to-back windows: `clean_in` toggled 20 times with ≥BOUNCE_TICKS+1 ticks between changes -> a downstream debouncer with BOUNCE_TICKS ≥ this block's value tracks every level.

Source files
------------

// File: rtl/bounce_generator.sv
// bounce_generator: emulates a bouncing switch; chatters for BOUNCE_TICKS ticks after each change of clean_in, then settles (BOUNCE_GEN_LFSR_EN selects LFSR chatter; ports: clk, rst, tick, clean_in -> bouncy_out, busy)
module bounce_generator #(
  parameter int BOUNCE_TICKS = 10,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic clean_in,
  output logic bouncy_out,
  output logic busy
);
  localparam int CW = $clog2(BOUNCE_TICKS) + 1;
  localparam logic [1:0] S_STABLE_0 = 2'd0, S_BOUNCE_TO_1 = 2'd1, S_STABLE_1 = 2'd2, S_BOUNCE_TO_0 = 2'd3;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic s_new1, s_new0, s_cur;
  assign busy = state[0];
`ifdef BOUNCE_GEN_LFSR_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk)
    if (rst) lfsr <= LFSR_SEED;
    else if (tick) lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  always_comb begin
    s_new1 = lfsr[0];
    s_new0 = lfsr[0];
    s_cur = lfsr[0];
  end
`else
  logic unused_seed;
  assign unused_seed = ^LFSR_SEED;
  always_comb begin
    s_new1 = 1'b1;
    s_new0 = 1'b0;
    s_cur = ~state[1] ^ cnt[0];
  end
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_STABLE_0;
      cnt <= '0;
      bouncy_out <= 1'b0;
    end else if (tick) begin
      case (state)
        S_STABLE_0:
          if (clean_in) begin
            state <= S_BOUNCE_TO_1;
            cnt <= CW'(1);
            bouncy_out <= s_new1;
          end else bouncy_out <= 1'b0;
        S_STABLE_1:
          if (!clean_in) begin
            state <= S_BOUNCE_TO_0;
            cnt <= CW'(1);
            bouncy_out <= s_new0;
          end else bouncy_out <= 1'b1;
        S_BOUNCE_TO_1:
          if (!clean_in) begin
            state <= S_BOUNCE_TO_0;
            cnt <= CW'(1);
            bouncy_out <= s_new0;
          end else if (cnt == CW'(BOUNCE_TICKS)) begin
            state <= S_STABLE_1;
            bouncy_out <= 1'b1;
          end else begin
            bouncy_out <= s_cur;
            cnt <= cnt + 1'b1;
          end
        S_BOUNCE_TO_0:
          if (clean_in) begin
            state <= S_BOUNCE_TO_1;
            cnt <= CW'(1);
            bouncy_out <= s_new1;
          end else if (cnt == CW'(BOUNCE_TICKS)) begin
            state <= S_STABLE_0;
            bouncy_out <= 1'b0;
          end else begin
            bouncy_out <= s_cur;
            cnt <= cnt + 1'b1;
          end
        default: begin
          state <= S_STABLE_0;
          bouncy_out <= 1'b0;
        end
      endcase
    end
endmodule
